led_frame_buf: RTL

LED_FRAME_BUF -- requirements
Module: led_frame_buf

---
 rtl/led_frame_buf.sv | 95 +++++++++
 1 files changed

// File: rtl/led_frame_buf.sv
// Double-buffered digit store for a multiplexed LED display: the writer fills the
// back array, and the whole frame moves to the front array only at the scanner's frame_end.
module led_frame_buf #(
   parameter int             N_DIG    = 8,
   parameter int             DW       = 5,
   parameter logic [DW-1:0]  RST_CODE = 5'h18
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [2:0]    wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_last,
   input  logic [2:0]    scan_ptr,
   input  logic          frame_end,
   output logic [DW-1:0] rd_data,
   output logic          pending,
   output logic          swap_pulse,
   output logic [7:0]    swap_cnt
);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t        state_r;
   logic [DW-1:0] back_r  [N_DIG];
   logic [DW-1:0] front_r [N_DIG];
   logic [DW-1:0] rd_data_r;
   logic          wr_ready_r;
   logic          pending_r;
   logic          swap_pulse_r;
   logic [7:0]    swap_cnt_r;

   // Frame FSM, both buffers and every registered output.
   // Reading front_r here returns the pre-swap value, so a swap shows on rd_data one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= FILL;
         back_r       <= '{default: RST_CODE};
         front_r      <= '{default: RST_CODE};
         rd_data_r    <= RST_CODE;
         wr_ready_r   <= 1'b1;
         pending_r    <= 1'b0;
         swap_pulse_r <= 1'b0;
         swap_cnt_r   <= 8'd0;
      end else begin
         rd_data_r    <= front_r[scan_ptr];
         swap_pulse_r <= 1'b0;
         case (state_r)
            FILL: begin
               // frame_end is deliberately ignored here, including when it coincides with wr_last
               if (wr_valid) begin
                  back_r[wr_addr] <= wr_data;
                  if (wr_last) begin
                     state_r    <= PEND;
                     wr_ready_r <= 1'b0;
                     pending_r  <= 1'b1;
                  end else begin
                     state_r    <= FILL;
                  end
               end else begin
                  state_r <= FILL;
               end
            end
            PEND: begin
               if (frame_end) begin
                  front_r      <= back_r;
                  state_r      <= FILL;
                  wr_ready_r   <= 1'b1;
                  pending_r    <= 1'b0;
                  swap_pulse_r <= 1'b1;
                  swap_cnt_r   <= swap_cnt_r + 8'd1;
               end else begin
                  state_r <= PEND;
               end
            end
            default: begin
               state_r    <= FILL;
               wr_ready_r <= 1'b1;
               pending_r  <= 1'b0;
            end
         endcase
      end
   end

   assign wr_ready   = wr_ready_r;
   assign rd_data    = rd_data_r;
   assign pending    = pending_r;
   assign swap_pulse = swap_pulse_r;
   assign swap_cnt   = swap_cnt_r;

endmodule
